// File: rtl/inv_add_round_key_stage.sv
// Inverse-cipher AddRoundKey stage with a local round-key store.
// Rounds are applied from NR down to 0; one output register, full rate.
module inv_add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_we,
  input  logic [3:0]   key_idx,
  input  logic [127:0] key_data,
  input  logic         key_clear,
  output logic         keys_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_mix_en,
  output logic         out_last,
  output logic         key_err
);

  localparam logic [3:0] LAST_IDX = 4'(NR);
  localparam logic [0:0] WAIT_KEYS = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;

  logic [127:0] keys [0:NR];
  logic [NR:0]  key_vld;
  logic [3:0]   rnd_cnt;
  logic [0:0]   state;

  logic         blk_idle;
  logic         idx_ok;
  logic         key_wr;
  logic         key_bad;
  logic         xfer;
  logic         mix_nxt;
  logic [3:0]   rnd_nxt;
  logic [127:0] rkey;

  assign blk_idle   = (rnd_cnt == LAST_IDX);
  assign idx_ok     = (key_idx <= LAST_IDX);
  assign key_wr     = key_we && !key_clear && idx_ok && blk_idle;
  assign key_bad    = key_we && !key_clear && !(idx_ok && blk_idle);
  assign keys_ready = &key_vld;
  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign xfer       = in_valid && in_ready && !key_clear;
  assign rkey       = keys[rnd_cnt];
  assign mix_nxt    = (rnd_cnt != 4'd0) && (rnd_cnt != LAST_IDX);
  assign rnd_nxt    = (rnd_cnt == 4'd0) ? LAST_IDX : rnd_cnt - 4'd1;

  // Key contents need no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (key_wr) begin
      keys[key_idx] <= key_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_vld    <= '0;
      rnd_cnt    <= LAST_IDX;
      state      <= WAIT_KEYS;
      out_valid  <= 1'b0;
      out_state  <= '0;
      out_round  <= '0;
      out_mix_en <= 1'b0;
      out_last   <= 1'b0;
      key_err    <= 1'b0;
    end else if (key_clear) begin
      key_vld   <= '0;
      rnd_cnt   <= LAST_IDX;
      state     <= WAIT_KEYS;
      out_valid <= 1'b0;
    end else begin
      if (key_wr) begin
        key_vld[key_idx] <= 1'b1;
      end
      if (key_bad) begin
        key_err <= 1'b1;
      end
      if (state == WAIT_KEYS && keys_ready) begin
        state <= RUN;
      end
      if (xfer) begin
        out_valid  <= 1'b1;
        out_state  <= in_state ^ rkey;
        out_round  <= rnd_cnt;
        out_mix_en <= mix_nxt;
        out_last   <= (rnd_cnt == 4'd0);
        rnd_cnt    <= rnd_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Bench for inv_add_round_key_stage: queue scoreboard fed by a
// behavioural model, with FIPS-197 round keys built by key expansion.
module tb_inv_add_round_key_stage;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_we = 1'b0;
  logic [3:0]   key_idx = '0;
  logic [127:0] key_data = '0;
  logic         key_clear = 1'b0;
  logic         keys_ready;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_mix_en;
  logic         out_last;
  logic         key_err;

  inv_add_round_key_stage #(.NR(NR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_we(key_we),
    .key_idx(key_idx),
    .key_data(key_data),
    .key_clear(key_clear),
    .keys_ready(keys_ready),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_state(in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .out_round(out_round),
    .out_mix_en(out_mix_en),
    .out_last(out_last),
    .key_err(key_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         mix;
    logic         last;
  } exp_t;

  exp_t         q[$];
  logic [127:0] mkey [0:NR];
  bit           mvalid [0:NR];
  int           mrnd;
  bit           mrun;
  bit           mov;
  bit           merr;
  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:NR];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit all_valid();
    for (int i = 0; i <= NR; i++)
      if (!mvalid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      if (i != 0)
        for (int j = 1; j < 256; j++)
          if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
              ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4 * NR + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
            ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One clock of stimulus; the model predicts the pre-edge outputs
  // and advances by the block's transfer and key-store rules.
  task automatic step(input logic iv, input logic [127:0] st,
                      input logic ordy, input logic kwe,
                      input logic [3:0] kidx, input logic [127:0] kd,
                      input logic kclr);
    bit   eir;
    bit   xf;
    bit   allv;
    int   pr;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_state  = st;
    out_ready = ordy;
    key_we    = kwe;
    key_idx   = kidx;
    key_data  = kd;
    key_clear = kclr;
    #1;
    allv = all_valid();
    eir  = mrun && (!mov || ordy);
    chk("in_ready", in_ready, eir);
    chk("out_valid", out_valid, mov);
    chk("keys_ready", keys_ready, allv);
    chk("key_err", key_err, merr);
    xf = iv && eir && !kclr;
    pr = mrnd;
    if (kclr) begin
      for (int i = 0; i <= NR; i++) mvalid[i] = 1'b0;
      mrnd = NR;
      mrun = 1'b0;
      mov  = 1'b0;
    end else begin
      if (xf) begin
        e.st   = st ^ mkey[pr];
        e.rnd  = 4'(pr);
        e.mix  = (pr >= 1) && (pr <= NR - 1);
        e.last = (pr == 0);
        q.push_back(e);
        mrnd = (pr == 0) ? NR : pr - 1;
        mov  = 1'b1;
      end else if (ordy) begin
        mov = 1'b0;
      end
      if (kwe) begin
        if (int'(kidx) > NR || pr != NR) begin
          merr = 1'b1;
        end else begin
          mkey[kidx]   = kd;
          mvalid[kidx] = 1'b1;
        end
      end
      if (allv) mrun = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, ordy, 1'b0, 4'd0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key_we    = 1'b0;
    key_clear = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_state", out_state, '0);
    chk("rst_flags", {out_valid, out_round, out_mix_en, out_last,
                      key_err, keys_ready, in_ready}, '0);
    q.delete();
    for (int i = 0; i <= NR; i++) mvalid[i] = 1'b0;
    mrnd  = NR;
    mrun  = 1'b0;
    mov   = 1'b0;
    merr  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic load_fips();
    for (int i = 0; i <= NR; i++)
      step(1'b0, '0, 1'b1, 1'b1, 4'(i), rk[i], 1'b0);
    idle(1'b1);
  endtask

  task automatic load_rand();
    for (int i = 0; i <= NR; i++)
      step(1'b0, '0, 1'b1, 1'b1, 4'(i), rnd128(), 1'b0);
    idle(1'b1);
  endtask

  // Output monitor: the head of the queue must be on the outputs for
  // every valid cycle and leaves the queue on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got round %0d want none",
                   out_round);
        end else begin
          chk("out_state", out_state, q[0].st);
          chk("out_tag", {out_round, out_mix_en, out_last},
              {q[0].rnd, q[0].mix, q[0].last});
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit kc;
    bit kw;
    int miss;
    mrnd = NR;
    build_sbox();
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_reset();

    load_fips();
    step(1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 1'b1,
         1'b0, 4'd0, '0, 1'b0);
    #1;
    chk("fips_out", out_state, 128'he9317db5cb322c723d2e895faf090794);
    chk("fips_tag", {out_round, out_mix_en, out_last},
        {4'd10, 1'b0, 1'b0});
    for (int i = 0; i < NR; i++)
      step(1'b1, rnd128(), 1'b1, 1'b0, 4'd0, '0, 1'b0);
    idle(1'b1);

    step(1'b0, '0, 1'b1, 1'b1, 4'd12, rnd128(), 1'b0);
    #1;
    chk("err_idx12", key_err, 1'b1);
    chk("kr_idx12", keys_ready, 1'b1);

    do_reset();
    load_fips();
    step(1'b1, rnd128(), 1'b1, 1'b0, 4'd0, '0, 1'b0);
    step(1'b1, rnd128(), 1'b1, 1'b1, 4'd3, rnd128(), 1'b0);
    #1;
    chk("err_midblock", key_err, 1'b1);

    for (int i = 0; i < 5; i++)
      step(1'b1, rnd128(), 1'b0, 1'b0, 4'd0, '0, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'b1, rnd128(), 1'b1, 1'b0, 4'd0, '0, 1'b0);

    for (int i = 0; i < 20 && mrnd != 5; i++)
      step(1'b1, rnd128(), 1'b1, 1'b0, 4'd0, '0, 1'b0);
    step(1'b1, rnd128(), 1'b1, 1'b0, 4'd0, '0, 1'b1);
    #1;
    chk("clr_keys_ready", keys_ready, 1'b0);
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b0);
    load_rand();
    step(1'b1, rnd128(), 1'b1, 1'b0, 4'd0, '0, 1'b0);
    #1;
    chk("clr_round", out_round, 4'd10);

    for (int n = 0; n < 400; n++) begin
      miss = -1;
      for (int i = NR; i >= 0; i--) if (!mvalid[i]) miss = i;
      kc = ($urandom % 80) == 0;
      if (miss >= 0 && mrnd == NR) begin
        step($urandom % 4 != 0, rnd128(), 1'b1, 1'b1, 4'(miss),
             rnd128(), 1'b0);
      end else begin
        kw = ($urandom % 16) == 0;
        step($urandom % 4 != 0, rnd128(), kc || ($urandom % 4 != 0),
             kw, 4'($urandom % 14), rnd128(), kc);
      end
    end

    for (int i = 0; i < 3; i++)
      step(1'b1, rnd128(), 1'b1, 1'b0, 4'd0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("queue_empty", 128'(q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_add_round_key_stage.md
INV_ADD_ROUND_KEY_STAGE -- requirements
Module: inv_add_round_key_stage

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning number of cipher rounds (round keys indexed 0..NR).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port key_we, input, 1, round-key write strobe.
REQ-005 The block SHALL have port key_idx, input, 4, round-key index written.
REQ-006 The block SHALL have port key_data, input, 128, round-key value, byte 0 at [127:120].
REQ-007 The block SHALL have port key_clear, input, 1, invalidate all stored round keys.
REQ-008 The block SHALL have port keys_ready, output, 1, high when all NR+1 keys are valid.
REQ-009 The block SHALL have port in_valid, input, 1, upstream state valid.
REQ-010 The block SHALL have port in_ready, output, 1, stage accepts in_state this cycle.
REQ-011 The block SHALL have port in_state, input, 128, state entering AddRoundKey, same byte order as key_data.
REQ-012 The block SHALL have port out_valid, input-side registered output, 1, out_state valid.
REQ-013 The block SHALL have port out_ready, input, 1, downstream (inverse MixColumns / round mux) accepts.
REQ-014 The block SHALL have port out_state, output, 128, in_state XOR selected round key.
REQ-015 The block SHALL have port out_round, output, 4, round index whose key was applied.
REQ-016 The block SHALL have port out_mix_en, output, 1, high when out_round in 1..NR-1 (downstream applies inverse MixColumns).
REQ-017 The block SHALL have port out_last, output, 1, high when out_round = 0 (plaintext complete).
REQ-018 The block SHALL have port key_err, output, 1, sticky, set on a rejected key write.

Function
REQ-019 Key store SHALL hold NR+1 128-bit entries plus one valid bit each; keys_ready = AND of all valid bits.
REQ-020 key_we with key_idx <= NR SHALL write entry and set its valid bit, unless rejected by REQ-022.
REQ-021 key_we with key_idx > NR SHALL be ignored and set key_err.
REQ-022 key_we while rnd_cnt != NR (block in progress) SHALL be ignored and set key_err.
REQ-023 key_clear SHALL clear all valid bits, force rnd_cnt to NR, clear out_valid next cycle; key_clear wins over simultaneous key_we and transfers.
REQ-024 State machine: WAIT_KEYS (keys_ready=0, in_ready=0) -> RUN when keys_ready=1; RUN -> WAIT_KEYS on key_clear.
REQ-025 in_ready SHALL equal (state=RUN) AND (out_valid=0 OR out_ready=1); single output register, full throughput.
REQ-026 Transfer occurs when in_valid AND in_ready; out_state SHALL equal in_state XOR key[rnd_cnt], registered, latency 1 cycle.
REQ-027 On transfer, out_round <= rnd_cnt; rnd_cnt decrements; at 0 it wraps to NR (next block).
REQ-028 A same-cycle key_we and transfer SHALL use the pre-write key value (read-before-write).
REQ-029 out_valid SHALL hold, with out_state/out_round/out_mix_en/out_last stable, until out_ready; simultaneous drain and accept replaces contents without bubble.
REQ-030 in_valid while in_ready=0 SHALL not change any state.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force: valid bits 0, rnd_cnt=NR, state WAIT_KEYS, out_valid=0, out_state=0, out_round=0, out_mix_en=0, out_last=0, key_err=0, keys_ready=0, in_ready=0.
REQ-032 Reset mid-block SHALL discard the block; key contents need not be cleared but SHALL be invalid.

Verification
REQ-033 Load keys 0..10 from FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c; in_state 3925841d02dc09fbdc118597196a0b32 -> next cycle out_state e9317db5cb322c723d2e895faf090794, out_round 10, out_mix_en 0, out_last 0.
REQ-034 Stream 11 states back-to-back with out_ready=1 -> out_round 10,9..0, out_mix_en high for 9..1, out_last only on 0, in_ready never low.
REQ-035 Hold out_ready=0 for 5 cycles with in_valid=1 -> out_state stable, in_ready=0, no round consumed; release -> one transfer per cycle resumes.
REQ-036 key_we idx 12 -> key_err=1, keys_ready unchanged; key_we after first transfer of a block -> ignored, key_err=1.
REQ-037 key_clear at round 5 -> keys_ready=0, out_valid=0, in_ready=0; reload keys -> next transfer uses round 10.
REQ-038 rst_n=0 mid-block for one cycle -> all outputs 0, keys_ready=0.
